// File: rtl/dly_tap_cal.sv
// Delay-chain tap calibrator: launches an edge, samples the thermometer taps 2^AVG_LOG2 times and averages.
// Optional bubble detection on ERR is compiled in with `define DLY_TAP_CAL_BUBBLE_CHK_EN.
module dly_tap_cal #(
  parameter int TAPS     = 16,
  parameter int AVG_LOG2 = 2,
  parameter int CW       = 5
) (
  input  logic            clk_i,
  input  logic            rn_i,
  input  logic            start_i,
  input  logic [TAPS-1:0] tap_in_i,
  output logic            launch_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [CW-1:0]   code_o,
  output logic            err_o
);

  localparam int AW = CW + AVG_LOG2;
  localparam int SW = AVG_LOG2 + 1;
  localparam logic [SW-1:0] NSAMP = SW'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SAMPLE,
    S_CLR1,
    S_CLR2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   code_q, code_d;
  logic            launch_q, launch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   tap_cnt;

  // Index of the lowest zero tap; TAPS when the edge ran through the whole chain.
  function automatic logic [CW-1:0] tap_count(input logic [TAPS-1:0] t);
    logic [CW-1:0] c;
    c = CW'(TAPS);
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (!t[i]) c = CW'(i);
    end
    return c;
  endfunction

`ifdef DLY_TAP_CAL_BUBBLE_CHK_EN
  logic err_q, err_d;

  // A clean sample is exactly c ones from bit 0 upward; anything else is a bubble.
  function automatic logic has_bubble(input logic [TAPS-1:0] t, input logic [CW-1:0] c);
    logic [TAPS-1:0] m;
    for (int i = 0; i < TAPS; i++) begin
      m[i] = (i < int'(c));
    end
    return (t != m);
  endfunction
`endif

  assign tap_cnt = tap_count(tap_in_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DLY_TAP_CAL_BUBBLE_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LAUNCH;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef DLY_TAP_CAL_BUBBLE_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LAUNCH: state_d = S_SAMPLE;
      S_SAMPLE: begin
        state_d = S_CLR1;
        acc_d   = acc_q + AW'(tap_cnt);
        cnt_d   = cnt_q + SW'(1);
`ifdef DLY_TAP_CAL_BUBBLE_CHK_EN
        if (has_bubble(tap_in_i, tap_cnt)) err_d = 1'b1;
`endif
      end
      S_CLR1: state_d = S_CLR2;
      S_CLR2: begin
        if (cnt_q < NSAMP) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
          code_d  = acc_q[AW-1:AVG_LOG2];
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    launch_d = (state_d == S_LAUNCH) || (state_d == S_SAMPLE);
  end

  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef DLY_TAP_CAL_BUBBLE_CHK_EN
  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign launch_o = launch_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign code_o   = code_q;

endmodule

// File: doc/dly_tap_cal.md
DLY_TAP_CAL -- requirements
Module: dly_tap_cal

Interface
REQ-001: Parameter TAPS, default 16, is the number of delay-chain taps sampled.
REQ-002: Parameter AVG_LOG2, default 2, sets samples per measurement to 2^AVG_LOG2.
REQ-003: Parameter CW, default 5, is the CODE width and SHALL equal clog2(TAPS+1).
REQ-004: CLK  input  1  sole clock, rising edge.
REQ-005: RN  input  1  asynchronous active-low reset.
REQ-006: START  input  1  request one measurement; sampled only in IDLE.
REQ-007: TAP_IN  input  TAPS  thermometer taps from the delay chain; bit 0 is the earliest tap.
REQ-008: LAUNCH  output  1  registered edge driven into the delay-chain input.
REQ-009: BUSY  output  1  high from the cycle after accepted START until DONE.
REQ-010: DONE  output  1  one-cycle pulse; CODE is valid from this cycle.
REQ-011: CODE  output  CW  averaged tap count, held until the next DONE.
REQ-012: ERR  output  1  bubble detected in any sample of the current measurement.

Function
REQ-013: The FSM SHALL have states IDLE, LAUNCH, SAMPLE, CLR1 and CLR2, all registered on CLK.
REQ-014: In IDLE with START=1 at an edge, the FSM SHALL go to LAUNCH, clear the accumulator, sample counter and ERR, and set BUSY=1.
REQ-015: LAUNCH=1 in the LAUNCH and SAMPLE states, and LAUNCH=0 in all other states.
REQ-016: LAUNCH SHALL advance to SAMPLE after one cycle.
REQ-017: At the edge leaving SAMPLE, the block SHALL capture TAP_IN and add its decoded count to the accumulator.
REQ-018: SAMPLE SHALL then advance to CLR1, and CLR1 to CLR2, which gives the chain a two-cycle drain.
REQ-019: At the edge leaving CLR2, if fewer than 2^AVG_LOG2 samples have been taken, the FSM SHALL go to LAUNCH.
REQ-020: Otherwise, at that edge it SHALL load CODE, pulse DONE for one cycle, clear BUSY and return to IDLE.
REQ-021: Decoded count is the index of the lowest zero bit of TAP_IN, or TAPS if all bits are one (range 0..TAPS).
REQ-022: The accumulator SHALL be CW+AVG_LOG2 bits wide with no overflow possible.
REQ-023: CODE = accumulator >> AVG_LOG2, truncated with no rounding.
REQ-024: Latency: DONE SHALL be high in the cycle after edge t0 + 4*2^AVG_LOG2, where t0 is the edge at which START was accepted (16 edges at default).
REQ-025: START while BUSY=1 SHALL be ignored, and no request SHALL be queued.
REQ-026: START held high SHALL begin a new measurement at the first IDLE edge after DONE.
REQ-027: TAP_IN is sampled by a single register; metastability hardening is outside this block.

Reset
REQ-028: RN=0 SHALL immediately force IDLE and set LAUNCH, BUSY, DONE, ERR, CODE, the accumulator and the sample counter to 0.
REQ-029: Reset mid-measurement SHALL discard the partial result, and no DONE SHALL follow.
REQ-030: After RN deasserts, the first accepted START SHALL behave exactly as from power-up.

Configuration
REQ-031: Macro DLY_TAP_CAL_BUBBLE_CHK_EN defined: a sample with any 1 above its lowest 0 SHALL set ERR.
REQ-032: With the macro defined, ERR SHALL be sticky until the next accepted START or reset, and averaging SHALL be unaffected.
REQ-033: Macro undefined: the ERR port SHALL remain present, tied to 0, with no detection logic.

Verification
REQ-034: Assert RN=0 mid-SAMPLE -> LAUNCH, BUSY, DONE, ERR and CODE all 0 within the same cycle; no DONE follows release.
REQ-035: TAP_IN=16'h00FF on all samples, START pulse -> four LAUNCH pulses, DONE 16 edges after START, CODE=8, ERR=0.
REQ-036: Per-sample TAP_IN 16'h001F,16'h003F,16'h003F,16'h007F -> CODE=6.
REQ-037: Per-sample TAP_IN counts 5,5,5,6 -> CODE=5 (truncation check).
REQ-038: TAP_IN=16'hFFFF -> CODE=16, and TAP_IN=16'h0000 -> CODE=0.
REQ-039: TAP_IN=16'h00F7 with the macro defined -> count 3 and ERR=1 held to the next START; with the macro undefined -> ERR=0.
REQ-040: START pulsed while BUSY -> no effect, exactly one DONE.
REQ-041: START held high -> back-to-back measurements with DONE every 17 cycles.
